// File: rtl/multicycle_alu.sv
// multicycle_alu: MIPS execute-stage ALU; single-cycle logic/arith/LUI, iterative 1-bit/cycle SLL/SRL.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            ALUOperation,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [4:0]            shamt,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  illegal_op
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] work, shifted, op_res;
  logic [CW-1:0]         cnt;
  logic                  srl_q, legal, is_shift;
  assign legal    = !ALUOperation[3];
  assign is_shift = ALUOperation[3:1] == 3'b011;
  assign shifted  = srl_q ? work >> 1 : work << 1;
  always_comb
    op_res = ALUOperation[2:0] == 3'd0 ? A & B :
             ALUOperation[2:0] == 3'd1 ? A | B :
             ALUOperation[2:0] == 3'd2 ? ~(A | B) :
             ALUOperation[2:0] == 3'd3 ? A + B :
             ALUOperation[2:0] == 3'd4 ? A - B :
             ALUOperation[2:0] == 3'd5 ? B << 16 : B;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  assign Zero = ALUResult == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      work       <= '0;
      cnt        <= '0;
      srl_q      <= 1'b0;
      ALUResult  <= '0;
      illegal_op <= 1'b0;
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        ALUResult <= shifted;
        state     <= DONE;
      end
    end else if (start) begin
      // shamt==0 shifts fall through with op_res==B and finish in one cycle
      work       <= B;
      cnt        <= CW'(shamt);
      srl_q      <= ALUOperation[0];
      illegal_op <= !legal;
      if (is_shift && shamt != 5'd0) state <= SHIFT;
      else begin
        ALUResult <= legal ? op_res : '0;
        state     <= DONE;
      end
    end else begin
      illegal_op <= 1'b0;
      state      <= IDLE;
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed self-checking bench for multicycle_alu.
module tb_multicycle_alu;
  logic        clk = 0, reset = 0, start = 0;
  logic [3:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic [4:0]  shamt = 0;
  logic        busy, done, zero, illegal;
  logic [31:0] res;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(op), .A(a), .B(b),
    .shamt(shamt), .busy(busy), .done(done), .ALUResult(res), .Zero(zero),
    .illegal_op(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launches one op, scrambles inputs and pulses start while busy, then checks the completion.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s,
                        input logic [31:0] er, input logic ei);
    int lat, nb, el;
    logic moved;
    logic [31:0] prev;
    lat = 0; nb = 0; moved = 0;
    el = ((o == 4'd6 || o == 4'd7) && s != 0) ? int'(s) + 1 : 1;
    @(negedge clk);
    op = o; a = x; b = y; shamt = s; start = 1; prev = res;
    do begin
      @(negedge clk);
      lat++;
      if (busy) begin
        nb++;
        if (res !== prev) moved = 1;
        start = lat[0]; op = 4'h0; a = $urandom; b = $urandom; shamt = 5'd1;
      end
    end while (!done && lat < 40);
    start = 0;
    check({tag, " done"}, 32'(done), 1);
    check({tag, " latency"}, lat, el);
    check({tag, " busy_cycles"}, nb, el - 1);
    check({tag, " hold"}, 32'(moved), 0);
    check({tag, " result"}, res, er);
    check({tag, " zero"}, 32'(zero), 32'(er == 0));
    check({tag, " illegal"}, 32'(illegal), 32'(ei));
  endtask

  initial begin
    int nd;
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst illegal", 32'(illegal), 0);
    check("rst result", res, 0);
    check("rst zero", 32'(zero), 1);
    @(negedge clk) reset = 1;

    run_op("add", 4'd3, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 0);
    run_op("sub", 4'd4, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 0);
    run_op("lui", 4'd5, 32'hAAAA_5555, 32'h0000_1234, 5'd0, 32'h1234_0000, 0);
    run_op("nor", 4'd2, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, 32'hF0F0_FF00, 0);
    run_op("sll31", 4'd6, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 0);
    run_op("srl4", 4'd7, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 0);
    run_op("srl0", 4'd7, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 0);
    run_op("sll3", 4'd6, 32'h0, 32'h8000_0001, 5'd3, 32'h0000_0008, 0);

    @(negedge clk); op = 4'd0; a = 32'hF0; b = 32'h3C; start = 1;
    @(negedge clk); check("b2b and done", 32'(done), 1); check("b2b and", res, 32'h30); op = 4'd1;
    @(negedge clk); check("b2b or done", 32'(done), 1); check("b2b or", res, 32'hFC); start = 0;
    @(negedge clk); check("b2b idle done", 32'(done), 0);

    run_op("ill9", 4'd9, 32'h1, 32'h1, 5'd0, 32'h0, 1);
    @(negedge clk);
    check("ill9 after done", 32'(done), 0);
    check("ill9 after illegal", 32'(illegal), 0);
    run_op("illF", 4'hF, 32'h7, 32'h9, 5'd0, 32'h0, 1);

    @(negedge clk); op = 4'd0; a = 32'hFF; b = 32'hFF; start = 1;
    @(posedge clk); #2 start = 0;
    check("pre-arst result", res, 32'hFF);
    reset = 0;
    #1;
    check("arst busy", 32'(busy), 0);
    check("arst done", 32'(done), 0);
    check("arst result", res, 0);
    check("arst zero", 32'(zero), 1);
    @(negedge clk) reset = 1;

    @(negedge clk); op = 4'd6; a = 0; b = 32'h1; shamt = 5'd20; start = 1;
    @(negedge clk) start = 0;
    repeat (4) @(negedge clk);
    check("mid-shift busy", 32'(busy), 1);
    #2 reset = 0;
    #1 check("shift-rst busy", 32'(busy), 0);
    @(negedge clk) reset = 1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("shift-rst no done", nd, 0);
    run_op("after-rst", 4'd6, 32'h0, 32'h3, 5'd2, 32'hC, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
